pipelined_adder: RTL and testbench

- Parametrised successor to the 8-bit ripple adder: WIDTH-bit add/subtract split into STAGES carry-chained register slices.
- Accepts one operand pair per cycle with a valid/ready handshake; results emerge STAGES cycles later.
- Adds subtract mode and a signed-overflow flag.
- Sits in the arithmetic datapath wherever a wide adder must meet timing at clock rate.

---
 rtl/arith_pkg.sv | 25 ++
 rtl/adder_slice.sv | 62 ++++++
 rtl/pipelined_adder.sv | 114 +++++++++++
 tb/tb_pipelined_adder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic helpers: width math and parameter legality checks
// used by the pipelined adder and its slices.
package arith_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit legal_split(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One registered CW-bit add stage: registers partial sum, carry out,
// carry into its MSB (for overflow) and the slot's valid bit.
module adder_slice #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          valid_in,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic          valid_out,
  output logic [CW-1:0] s,
  output logic          cout,
  output logic          cmsb
);

  logic [CW:0]   total;
  logic          valid_d, valid_q;
  logic [CW-1:0] s_d, s_q;
  logic          cout_d, cout_q;
  logic          cmsb_d, cmsb_q;

  // NOTE: every always_comb output gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    total   = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    valid_d = valid_q;
    s_d     = s_q;
    cout_d  = cout_q;
    cmsb_d  = cmsb_q;
    if (enable) begin
      valid_d = valid_in;
      s_d     = total[CW-1:0];
      cout_d  = total[CW];
      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      cmsb_d  = a[CW-1] ^ b[CW-1] ^ total[CW-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments; every flop here is reset,
  // because the valid bit must clear and the data outputs are required to read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      cmsb_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      cmsb_q  <= cmsb_d;
    end
  end

  assign valid_out = valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign cmsb      = cmsb_q;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-chained register slices,
// with valid/ready handshake, full-pipeline stall and signed-overflow flag.
module pipelined_adder
  import arith_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (!legal_split(WIDTH, STAGES)) begin : g_bad_params
    $fatal(1, "pipelined_adder: WIDTH=%0d cannot be split into STAGES=%0d slices", WIDTH, STAGES);
  end

  logic             stall;
  logic             advance;
  logic [WIDTH-1:0] b_eff;

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;
  assign b_eff    = B ^ {WIDTH{Sub}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // a_src/b_src: operand bits not yet consumed when the slot enters stage k.
    logic [WIDTH-k*CW-1:0] a_src, b_src;
    logic                  c_in, v_in, c_out, v_out, cmsb;
    logic [CW-1:0]         s;
    logic [(k+1)*CW-1:0]   done;

    if (k == 0) begin : g_head
      assign a_src = A;
      assign b_src = b_eff;
      assign c_in  = Cin;
      assign v_in  = in_valid;
      assign done  = s;
    end else begin : g_tail
      localparam int REM = WIDTH - k*CW;
      logic [REM-1:0]  a_pend_d, a_pend_q;
      logic [REM-1:0]  b_pend_d, b_pend_q;
      logic [k*CW-1:0] lo_d, lo_q;

      always_comb begin
        a_pend_d = a_pend_q;
        b_pend_d = b_pend_q;
        lo_d     = lo_q;
        if (advance) begin
          a_pend_d = g_stage[k-1].a_src[WIDTH-(k-1)*CW-1:CW];
          b_pend_d = g_stage[k-1].b_src[WIDTH-(k-1)*CW-1:CW];
          lo_d     = g_stage[k-1].done;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_pend_q <= '0;
          b_pend_q <= '0;
          lo_q     <= '0;
        end else begin
          a_pend_q <= a_pend_d;
          b_pend_q <= b_pend_d;
          lo_q     <= lo_d;
        end
      end

      assign a_src = a_pend_q;
      assign b_src = b_pend_q;
      assign c_in  = g_stage[k-1].c_out;
      assign v_in  = g_stage[k-1].v_out;
      assign done  = {s, lo_q};
    end

    adder_slice #(.CW(CW)) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (advance),
      .valid_in  (v_in),
      .a         (a_src[CW-1:0]),
      .b         (b_src[CW-1:0]),
      .cin       (c_in),
      .valid_out (v_out),
      .s         (s),
      .cout      (c_out),
      .cmsb      (cmsb)
    );

    // Only the final slice's MSB carry is meaningful for Ovf.
    if (k != STAGES - 1) begin : g_mid
      logic cmsb_unused;
      assign cmsb_unused = cmsb;
    end
  end

  assign out_valid = g_stage[STAGES-1].v_out;
  assign Sum       = g_stage[STAGES-1].done;
  assign Cout      = g_stage[STAGES-1].c_out;
  assign Ovf       = g_stage[STAGES-1].c_out ^ g_stage[STAGES-1].cmsb;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: four parameter sets, directed corner
// cases, backpressure streaming, mid-flight reset and random sweeps.
module tb_pipelined_adder;

  localparam int N_DUT = 4;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  int dut_w [N_DUT] = '{8, 16, 32, 8};
  int dut_s [N_DUT] = '{2, 4, 1, 8};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       a_drv, b_drv;
  logic              cin_drv, sub_drv, out_rdy;
  logic [N_DUT-1:0]  in_vld, in_rdy, o_vld, o_cout, o_ovf;
  logic [7:0]        sum0, sum3;
  logic [15:0]       sum1;
  logic [31:0]       sum2;
  logic [31:0]       o_sum [N_DUT];

  assign o_sum[0] = {24'd0, sum0};
  assign o_sum[1] = {16'd0, sum1};
  assign o_sum[2] = sum2;
  assign o_sum[3] = {24'd0, sum3};

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_w8_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_vld[0]), .in_ready(in_rdy[0]),
    .A(a_drv[7:0]), .B(b_drv[7:0]), .Cin(cin_drv), .Sub(sub_drv),
    .out_valid(o_vld[0]), .out_ready(out_rdy), .Sum(sum0), .Cout(o_cout[0]), .Ovf(o_ovf[0]));

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_w16_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_vld[1]), .in_ready(in_rdy[1]),
    .A(a_drv[15:0]), .B(b_drv[15:0]), .Cin(cin_drv), .Sub(sub_drv),
    .out_valid(o_vld[1]), .out_ready(out_rdy), .Sum(sum1), .Cout(o_cout[1]), .Ovf(o_ovf[1]));

  pipelined_adder #(.WIDTH(32), .STAGES(1)) u_w32_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_vld[2]), .in_ready(in_rdy[2]),
    .A(a_drv), .B(b_drv), .Cin(cin_drv), .Sub(sub_drv),
    .out_valid(o_vld[2]), .out_ready(out_rdy), .Sum(sum2), .Cout(o_cout[2]), .Ovf(o_ovf[2]));

  pipelined_adder #(.WIDTH(8), .STAGES(8)) u_w8_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_vld[3]), .in_ready(in_rdy[3]),
    .A(a_drv[7:0]), .B(b_drv[7:0]), .Cin(cin_drv), .Sub(sub_drv),
    .out_valid(o_vld[3]), .out_ready(out_rdy), .Sum(sum3), .Cout(o_cout[3]), .Ovf(o_ovf[3]));

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    sel     = 0;
  int    bp_cnt  = 0;
  bit    mon_en  = 0;
  bit    lat_chk = 0;
  bit    bp_en   = 0;
  bit    hold_armed = 0;
  logic [33:0] held;
  exp_t  exp_q [$];
  exp_t  mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain wide add, overflow from the operand/result sign rule.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic su);
    logic [31:0] mask, aa, bb;
    logic [32:0] full;
    exp_t        e;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa     = a & mask;
    bb     = (su ? ~b : b) & mask;
    full   = {1'b0, aa} + {1'b0, bb} + {32'd0, ci};
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
    e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
    e.acc  = 0;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_en) begin
      out_rdy = (bp_cnt % 3 == 0);
      bp_cnt++;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_vld[sel] && !out_rdy) begin
        check("in_ready_stall", 64'(in_rdy[sel]), 64'd0);
        if (hold_armed)
          check("hold_outputs", 64'({o_ovf[sel], o_cout[sel], o_sum[sel]}), 64'(held));
        held       = {o_ovf[sel], o_cout[sel], o_sum[sel]};
        hold_armed = 1;
      end else begin
        hold_armed = 0;
        check("in_ready_free", 64'(in_rdy[sel]), 64'd1);
      end
      if (o_vld[sel] && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(o_vld[sel]), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sum",  64'(o_sum[sel]),  64'(mon_e.sum));
          check("cout", 64'(o_cout[sel]), 64'(mon_e.cout));
          check("ovf",  64'(o_ovf[sel]),  64'(mon_e.ovf));
          if (lat_chk) check("latency", 64'(cyc - mon_e.acc), 64'(dut_s[sel]));
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic su);
    exp_t e;
    int   budget;
    budget       = 0;
    a_drv        = a;
    b_drv        = b;
    cin_drv      = ci;
    sub_drv      = su;
    in_vld       = '0;
    in_vld[sel]  = 1'b1;
    forever begin
      @(negedge clk);
      if (in_rdy[sel]) break;
      budget++;
      if (budget > 500) begin
        check("accept_timeout", 64'(in_rdy[sel]), 64'd1);
        in_vld = '0;
        return;
      end
    end
    e     = model(dut_w[sel], a, b, ci, su);
    e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_vld = '0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 500) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    a_drv   = '0;
    b_drv   = '0;
    cin_drv = 1'b0;
    sub_drv = 1'b0;
    in_vld  = '0;
    out_rdy = 1'b1;

    #2;
    for (int i = 0; i < N_DUT; i++) begin
      check("reset_out_valid", 64'(o_vld[i]), 64'd0);
      check("reset_in_ready",  64'(in_rdy[i]), 64'd1);
      check("reset_sum",       64'(o_sum[i]), 64'd0);
    end
    check("reset_cout", 64'(o_cout), 64'd0);
    check("reset_ovf",  64'(o_ovf),  64'd0);

    @(negedge clk);
    #2;
    rst_n = 1'b1;
    sync();
    mon_en  = 1;
    lat_chk = 1;

    // Basic add, then confirm out_valid lasted a single cycle.
    sel = 0;
    send(32'h02, 32'h03, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    check("single_cycle_valid", 64'(o_vld[0]), 64'd0);
    sync();

    // Carry across the slice boundary, subtract with borrow, signed overflow.
    send(32'hFF, 32'h01, 1'b0, 1'b0);
    send(32'hFF, 32'hFF, 1'b1, 1'b0);
    send(32'h05, 32'h06, 1'b1, 1'b1);
    send(32'h7F, 32'h01, 1'b0, 1'b0);
    send(32'h80, 32'h01, 1'b1, 1'b1);
    drain();
    sync();

    // Streaming under backpressure 1,0,0 repeating.
    lat_chk = 0;
    bp_cnt  = 0;
    bp_en   = 1;
    for (int i = 0; i < 7; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    bp_en   = 0;
    out_rdy = 1'b1;
    drain();
    sync();

    // Reset with two transactions in flight and one result stalled at the output.
    out_rdy = 1'b0;
    send(32'h11, 32'h22, 1'b0, 1'b0);
    send(32'h33, 32'h44, 1'b1, 1'b0);
    @(negedge clk);
    check("pre_reset_valid", 64'(o_vld[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(o_vld[0]), 64'd0);
    check("async_reset_sum",   64'(o_sum[0]), 64'd0);
    check("async_reset_cout",  64'(o_cout[0]), 64'd0);
    check("async_reset_ovf",   64'(o_ovf[0]), 64'd0);
    exp_q.delete();
    hold_armed = 0;
    out_rdy    = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("no_stale_result", 64'(o_vld[0]), 64'd0);
    end
    sync();

    // Random sweep across all parameter sets with occasional bubbles.
    lat_chk = 1;
    for (int d = 0; d < N_DUT; d++) begin
      sel        = d;
      hold_armed = 0;
      for (int i = 0; i < 1000; i++) begin
        if ($urandom_range(0, 7) == 0) sync();
        send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain();
      sync();
    end

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
